// File: rtl/risc_datapath.sv
// Execution datapath: 8-entry register file, A/B/C pipeline registers,
// B-operand shifter, ALU and Z/N/V status register. Every state element is
// enable-driven by the control block; nothing is sequenced internally.
module risc_datapath #(
  parameter int WIDTH = 16,
  parameter int PCW   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       vsel,
  input  logic             write,
  input  logic             loada,
  input  logic             loadb,
  input  logic             asel,
  input  logic             bsel,
  input  logic             loadc,
  input  logic             loads,
  input  logic [2:0]       nsel,
  input  logic [2:0]       rn,
  input  logic [2:0]       rd,
  input  logic [2:0]       rm,
  input  logic [1:0]       shift,
  input  logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] sximm8,
  input  logic [WIDTH-1:0] sximm5,
  input  logic [WIDTH-1:0] mdata,
  input  logic [PCW-1:0]   pc,
  output logic [WIDTH-1:0] datapath_out,
  output logic             z_out,
  output logic             n_out,
  output logic             v_out
);

  logic [2:0]       regnum;
  logic             sel_valid;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] regs [0:7];
  logic [WIDTH-1:0] a_reg, b_reg, c_reg;
  logic [WIDTH-1:0] shift_out, ain, bin, alu_out;
  logic             alu_v;
  logic [2:0]       status;

  // One-hot field select; a non-one-hot nsel reads R0 and blocks writes
  always_comb begin
    regnum    = 3'd0;
    sel_valid = 1'b0;
    case (nsel)
      3'b100: begin regnum = rn; sel_valid = 1'b1; end
      3'b010: begin regnum = rd; sel_valid = 1'b1; end
      3'b001: begin regnum = rm; sel_valid = 1'b1; end
      default: begin regnum = 3'd0; sel_valid = 1'b0; end
    endcase
  end

  // Writeback source mux; PC is zero-extended to the word width
  always_comb begin
    case (vsel)
      2'b00:   wdata = mdata;
      2'b01:   wdata = sximm8;
      2'b10:   wdata = {{(WIDTH-PCW){1'b0}}, pc};
      default: wdata = c_reg;
    endcase
  end

  // Register file write port; read is combinational so same-cycle read sees old data
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (write && sel_valid) begin
      regs[regnum] <= wdata;
    end
  end

  assign rdata = regs[regnum];

  // Operand pipeline registers A and B
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      if (loada) a_reg <= rdata;
      if (loadb) b_reg <= rdata;
    end
  end

  // Shifter on the B operand
  always_comb begin
    case (shift)
      2'b00:   shift_out = b_reg;
      2'b01:   shift_out = {b_reg[WIDTH-2:0], 1'b0};
      2'b10:   shift_out = {1'b0, b_reg[WIDTH-1:1]};
      default: shift_out = {b_reg[WIDTH-1], b_reg[WIDTH-1:1]};
    endcase
  end

  assign ain = asel ? '0 : a_reg;
  assign bin = bsel ? sximm5 : shift_out;

  // ALU with signed-overflow detection for ADD and SUB only
  always_comb begin
    alu_out = '0;
    alu_v   = 1'b0;
    case (alu_op)
      2'b00: begin
        alu_out = ain + bin;
        alu_v   = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_out[WIDTH-1] != ain[WIDTH-1]);
      end
      2'b01: begin
        alu_out = ain + ~bin + WIDTH'(1);
        alu_v   = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_out[WIDTH-1] != ain[WIDTH-1]);
      end
      2'b10:   alu_out = ain & bin;
      default: alu_out = ~bin;
    endcase
  end

  // Result register C and status register, independently enabled
  always_ff @(posedge clk) begin
    if (!reset) begin
      c_reg  <= '0;
      status <= 3'b000;
    end else begin
      if (loadc) c_reg <= alu_out;
      if (loads) status <= {(alu_out == '0), alu_out[WIDTH-1], alu_v};
    end
  end

  assign datapath_out = c_reg;
  assign z_out        = status[2];
  assign n_out        = status[1];
  assign v_out        = status[0];

endmodule

// File: tb/tb_risc_datapath.sv
// Directed bench for risc_datapath: register contents are observed by routing
// them through B -> ALU -> C, since only C and the flags are visible.
module tb_risc_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  vsel;
  logic        write, loada, loadb, asel, bsel, loadc, loads;
  logic [2:0]  nsel, rn, rd, rm;
  logic [1:0]  shift, alu_op;
  logic [15:0] sximm8, sximm5, mdata;
  logic [7:0]  pc;
  logic [15:0] datapath_out;
  logic        z_out, n_out, v_out;

  int errors = 0;
  int checks = 0;

  risc_datapath #(.WIDTH(16), .PCW(8)) dut (
    .clk(clk), .reset(reset), .vsel(vsel), .write(write), .loada(loada),
    .loadb(loadb), .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads),
    .nsel(nsel), .rn(rn), .rd(rd), .rm(rm), .shift(shift), .alu_op(alu_op),
    .sximm8(sximm8), .sximm5(sximm5), .mdata(mdata), .pc(pc),
    .datapath_out(datapath_out), .z_out(z_out), .n_out(n_out), .v_out(v_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vsel = 2'b00; write = 0; loada = 0; loadb = 0; asel = 0; bsel = 0;
    loadc = 0; loads = 0; nsel = 3'b000; rn = 0; rd = 0; rm = 0;
    shift = 2'b00; alu_op = 2'b00; sximm8 = 0; sximm5 = 0; mdata = 0; pc = 0;
  endtask

  task automatic write_reg(input logic [2:0] idx, input logic [15:0] val);
    idle(); nsel = 3'b100; rn = idx; vsel = 2'b01; sximm8 = val; write = 1;
    step(); idle();
  endtask

  // R[idx] -> B, then C = 0 + B
  task automatic read_reg(input logic [2:0] idx, output logic [15:0] val);
    idle(); nsel = 3'b001; rm = idx; loadb = 1; step();
    idle(); asel = 1; loadc = 1; step();
    idle(); val = datapath_out;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    idle(); reset = 0; write = 1; nsel = 3'b100; rn = 3'd2; vsel = 2'b01;
    sximm8 = 16'h0033; loada = 1; loadb = 1; loadc = 1; loads = 1;
    asel = 1; bsel = 1; sximm5 = 16'hFFF0;
    step(); step();
    checks++; if (datapath_out !== 16'h0000) begin errors++;
      $display("FAIL reset_c: got %h want 0000", datapath_out); end
    checks++; if ({z_out, n_out, v_out} !== 3'b000) begin errors++;
      $display("FAIL reset_flags: got %b want 000", {z_out, n_out, v_out}); end
    reset = 1; idle();
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), v);
      checks++; if (v !== 16'h0000) begin errors++;
        $display("FAIL reset_r%0d: got %h want 0000", i, v); end
    end
    idle(); asel = 1; bsel = 1; sximm5 = 16'd5; loadc = 1; step(); idle();
    checks++; if (datapath_out !== 16'd5) begin errors++;
      $display("FAIL post_reset_add: got %h want 0005", datapath_out); end
  endtask

  task automatic test_mov();
    write_reg(3'd0, 16'd7);
    idle(); nsel = 3'b001; rm = 3'd0; loadb = 1; step();
    idle(); asel = 1; shift = 2'b01; loadc = 1; step(); idle();
    checks++; if (datapath_out !== 16'd14) begin errors++;
      $display("FAIL mov_lsl: got %h want 000e", datapath_out); end
  endtask

  task automatic test_overflow();
    write_reg(3'd1, 16'h7FFF);
    write_reg(3'd2, 16'h0001);
    idle(); nsel = 3'b100; rn = 3'd1; loada = 1; step();
    idle(); nsel = 3'b010; rd = 3'd2; loadb = 1; step();
    idle(); loadc = 1; loads = 1; alu_op = 2'b00; step(); idle();
    checks++; if (datapath_out !== 16'h8000) begin errors++;
      $display("FAIL ovf_add_c: got %h want 8000", datapath_out); end
    checks++; if ({z_out, n_out, v_out} !== 3'b011) begin errors++;
      $display("FAIL ovf_add_flags: got %b want 011", {z_out, n_out, v_out}); end
    // CMP R2,R2: status only
    idle(); nsel = 3'b001; rm = 3'd2; loada = 1; loadb = 1; step();
    idle(); alu_op = 2'b01; loads = 1; step(); idle();
    checks++; if ({z_out, n_out, v_out} !== 3'b100) begin errors++;
      $display("FAIL cmp_flags: got %b want 100", {z_out, n_out, v_out}); end
    checks++; if (datapath_out !== 16'h8000) begin errors++;
      $display("FAIL cmp_c_hold: got %h want 8000", datapath_out); end
    // Writeback C into R4, then 0x8000 - 1 overflows
    idle(); nsel = 3'b100; rn = 3'd4; vsel = 2'b11; write = 1; step();
    idle(); nsel = 3'b100; rn = 3'd4; loada = 1; step();
    idle(); nsel = 3'b010; rd = 3'd2; loadb = 1; step();
    idle(); alu_op = 2'b01; loadc = 1; loads = 1; step(); idle();
    checks++; if (datapath_out !== 16'h7FFF) begin errors++;
      $display("FAIL sub_ovf_c: got %h want 7fff", datapath_out); end
    checks++; if ({z_out, n_out, v_out} !== 3'b001) begin errors++;
      $display("FAIL sub_ovf_flags: got %b want 001", {z_out, n_out, v_out}); end
  endtask

  task automatic test_shift_logic();
    logic [15:0] exp_tab [4];
    exp_tab[0] = 16'h8001; exp_tab[1] = 16'h0002;
    exp_tab[2] = 16'h4000; exp_tab[3] = 16'hC000;
    write_reg(3'd5, 16'h8001);
    idle(); nsel = 3'b001; rm = 3'd5; loadb = 1; step();
    for (int s = 0; s < 4; s++) begin
      idle(); asel = 1; shift = 2'(s); loadc = 1; step(); idle();
      checks++; if (datapath_out !== exp_tab[s]) begin errors++;
        $display("FAIL shift_%0d: got %h want %h", s, datapath_out, exp_tab[s]); end
    end
    checks++; if ({z_out, n_out, v_out} !== 3'b001) begin errors++;
      $display("FAIL flags_hold: got %b want 001", {z_out, n_out, v_out}); end
    write_reg(3'd6, 16'h00F0);
    idle(); nsel = 3'b001; rm = 3'd6; loadb = 1; step();
    idle(); alu_op = 2'b11; loadc = 1; loads = 1; step(); idle();
    checks++; if (datapath_out !== 16'hFF0F) begin errors++;
      $display("FAIL mvn_c: got %h want ff0f", datapath_out); end
    checks++; if ({z_out, n_out, v_out} !== 3'b010) begin errors++;
      $display("FAIL mvn_flags: got %b want 010", {z_out, n_out, v_out}); end
    idle(); nsel = 3'b100; rn = 3'd5; loada = 1; step();
    idle(); alu_op = 2'b10; loadc = 1; loads = 1; step(); idle();
    checks++; if (datapath_out !== 16'h0000) begin errors++;
      $display("FAIL and_c: got %h want 0000", datapath_out); end
    checks++; if ({z_out, n_out, v_out} !== 3'b100) begin errors++;
      $display("FAIL and_flags: got %b want 100", {z_out, n_out, v_out}); end
  endtask

  task automatic test_same_cycle();
    write_reg(3'd3, 16'd1);
    idle(); nsel = 3'b010; rd = 3'd3; write = 1; vsel = 2'b01; sximm8 = 16'd9;
    loada = 1; step();
    // C <= A (old read), and reload A from R3 in the same edge
    idle(); bsel = 1; sximm5 = 0; loadc = 1; nsel = 3'b010; rd = 3'd3; loada = 1;
    step(); idle();
    checks++; if (datapath_out !== 16'd1) begin errors++;
      $display("FAIL same_cycle_old: got %h want 0001", datapath_out); end
    idle(); bsel = 1; sximm5 = 0; loadc = 1; step(); idle();
    checks++; if (datapath_out !== 16'd9) begin errors++;
      $display("FAIL same_cycle_new: got %h want 0009", datapath_out); end
  endtask

  task automatic test_invalid_nsel();
    logic [15:0] v;
    logic [15:0] exp_r [8];
    exp_r[0] = 16'h0007; exp_r[1] = 16'h7FFF; exp_r[2] = 16'h0001; exp_r[3] = 16'h0009;
    exp_r[4] = 16'h8000; exp_r[5] = 16'h8001; exp_r[6] = 16'h00F0; exp_r[7] = 16'h0000;
    idle(); nsel = 3'b000; rn = 3'd7; rd = 3'd7; rm = 3'd7; write = 1; vsel = 2'b01;
    sximm8 = 16'h0055; loada = 1; step();
    idle(); bsel = 1; sximm5 = 0; loadc = 1; step(); idle();
    checks++; if (datapath_out !== 16'h0007) begin errors++;
      $display("FAIL invalid_nsel_reads_r0: got %h want 0007", datapath_out); end
    idle(); nsel = 3'b111; rn = 3'd7; rd = 3'd6; rm = 3'd5; write = 1; vsel = 2'b01;
    sximm8 = 16'h0055; step(); idle();
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), v);
      checks++; if (v !== exp_r[i]) begin errors++;
        $display("FAIL invalid_nsel_r%0d: got %h want %h", i, v, exp_r[i]); end
    end
  endtask

  task automatic test_pc_mdata();
    logic [15:0] v;
    idle(); nsel = 3'b010; rd = 3'd7; vsel = 2'b10; pc = 8'hAB; write = 1; step();
    read_reg(3'd7, v);
    checks++; if (v !== 16'h00AB) begin errors++;
      $display("FAIL pc_wb: got %h want 00ab", v); end
    idle(); nsel = 3'b001; rm = 3'd7; vsel = 2'b00; mdata = 16'h1234; write = 1; step();
    read_reg(3'd7, v);
    checks++; if (v !== 16'h1234) begin errors++;
      $display("FAIL mdata_wb: got %h want 1234", v); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    idle(); nsel = 3'b100; rn = 3'd1; loada = 1; step();
    idle(); reset = 0; step(); reset = 1;
    idle(); bsel = 1; sximm5 = 0; loadc = 1; step(); idle();
    checks++; if (datapath_out !== 16'h0000) begin errors++;
      $display("FAIL mid_reset_a: got %h want 0000", datapath_out); end
    read_reg(3'd1, v);
    checks++; if (v !== 16'h0000) begin errors++;
      $display("FAIL mid_reset_r1: got %h want 0000", v); end
  endtask

  initial begin
    idle();
    reset = 0;
    test_reset();
    test_mov();
    test_overflow();
    test_shift_logic();
    test_same_cycle();
    test_invalid_nsel();
    test_pc_mdata();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
